// File: rtl/fwd_hazard_sb.sv
// fwd_hazard_sb: forwarding and load-use hazard scoreboard for an in-order
// pipeline. Destination tags of in-flight writes shift one stage per clock
// from EX towards WB. Every ID source operand is checked against them to
// produce a combinational stall and a registered forwarding select that is
// presented while the instruction sits in EX.
module fwd_hazard_sb #(
    parameter int NUM_RS = 2,
    parameter int STAGES = 3,
    parameter int AW     = 5,
    parameter int CNT_W  = 16,
    localparam int SW    = $clog2(STAGES)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 id_valid_i,
    input  logic [NUM_RS*AW-1:0] id_rs_i,
    input  logic [NUM_RS-1:0]    id_rs_used_i,
    input  logic [AW-1:0]        id_rd_i,
    input  logic                 id_regwrite_i,
    input  logic [SW-1:0]        id_ready_i,
    input  logic                 flush_i,
    output logic                 stall_o,
    output logic [NUM_RS*SW-1:0] fwd_sel_o,
    output logic [CNT_W-1:0]     stall_cnt_o
);

    // The last tracked stage (WB) writes a write-first register file, so a
    // producer there never needs forwarding and is never matched. Its tag
    // would only be retired, so only slots 0..STAGES-2 are stored.
    localparam int NSLOT = STAGES - 1;

    logic          slot_valid [NSLOT];
    logic [AW-1:0] slot_rd    [NSLOT];
    logic [SW-1:0] slot_ready [NSLOT];

    logic [NUM_RS-1:0]    port_hazard;
    logic [NUM_RS*SW-1:0] sel_pk;
    logic                 any_hazard;
    logic                 id_load;
    logic                 id_accept;

    // ------------------------------------------------------------------
    // Issue control
    // ------------------------------------------------------------------
    assign any_hazard = |port_hazard;

    // The stall is forced low while reset is asserted, and a flush wins over
    // a hazard seen in the same cycle.
    assign stall_o   = !rst_i && id_valid_i && !flush_i && any_hazard;

    // The ID instruction moves into EX this cycle.
    assign id_load   = id_valid_i && !stall_o && !flush_i;

    // Only real writes to a non-zero register are worth tracking.
    assign id_accept = id_load && id_regwrite_i && (id_rd_i != '0);

    // ------------------------------------------------------------------
    // Destination tag shift register
    // ------------------------------------------------------------------

    // Slot 0 takes the issuing producer, or a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_valid[0] <= 1'b0;
            slot_rd[0]    <= '0;
            slot_ready[0] <= '0;
        end else begin
            slot_valid[0] <= id_accept;
            slot_rd[0]    <= id_rd_i;
            slot_ready[0] <= id_ready_i;
        end
    end

    for (genvar gi = 1; gi < NSLOT; gi++) begin : g_shift
        // Each older slot takes the contents of the next younger one.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                slot_valid[gi] <= 1'b0;
                slot_rd[gi]    <= '0;
                slot_ready[gi] <= '0;
            end else begin
                slot_valid[gi] <= slot_valid[gi-1];
                slot_rd[gi]    <= slot_rd[gi-1];
                slot_ready[gi] <= slot_ready[gi-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-port match, hazard and select
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_port
        logic [AW-1:0] rs;
        logic          port_live;
        logic          hit;
        logic [SW-1:0] hit_idx;
        logic [SW-1:0] hit_rdy;
        logic [SW-1:0] hit_sel;
        logic          not_ready;

        assign rs        = id_rs_i[gi*AW +: AW];
        assign port_live = id_rs_used_i[gi] && (rs != '0);

        // Scan from the oldest forwardable slot down to slot 0 so that the
        // youngest matching producer is the one left standing.
        always_comb begin
            hit     = 1'b0;
            hit_idx = '0;
            hit_rdy = '0;
            hit_sel = '0;
            for (int j = NSLOT - 1; j >= 0; j--) begin
                if (slot_valid[j] && (slot_rd[j] == rs)) begin
                    hit     = 1'b1;
                    hit_idx = SW'(j);
                    hit_rdy = slot_ready[j];
                    hit_sel = SW'(j + 1);
                end
            end
        end

        // The result exists once the producer has reached its ready stage;
        // until then the consumer must wait in ID.
        assign not_ready = hit_rdy > hit_idx;

        assign port_hazard[gi]     = port_live && hit && not_ready;
        assign sel_pk[gi*SW +: SW] = (port_live && hit && !not_ready) ? hit_sel : '0;
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------

    // Selects follow the instruction into EX; a bubble forwards nothing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fwd_sel_o <= '0;
        end else if (id_load) begin
            fwd_sel_o <= sel_pk;
        end else begin
            fwd_sel_o <= '0;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: doc/fwd_hazard_sb.md
# fwd_hazard_sb

Parametrised forwarding and hazard scoreboard for the in-order RISC-V pipeline.
- Tracks every in-flight register write from EX to WB in a shift register of destination tags.
- Checks each source operand decoded in ID against those tags.
- Produces a combinational load-use stall and registered forwarding selects that line up with the instruction's EX cycle.
- Generalises the fixed two-source, EX/MEM + MEM/WB forwarding check to N source ports, deeper pipelines and per-instruction result latency, and adds a stall performance counter.

## Interface
- NUM_RS, 2, source-operand ports per instruction
- STAGES, 3, tracked stages after ID (slot 0 = EX … slot STAGES-1 = WB); must be ≥ 2
- AW, 5, register address width
- CNT_W, 16, stall counter width
- Derived: SW = $clog2(STAGES), the width of one select field and of the ready-stage field
- clk_i  in  1  clock; one clock domain, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- id_valid_i  in  1  ID holds a valid instruction
- id_rs_i  in  NUM_RS*AW  source register addresses; port p = bits [p*AW +: AW]
- id_rs_used_i  in  NUM_RS  port p actually reads its register
- id_rd_i  in  AW  destination register
- id_regwrite_i  in  1  instruction writes rd
- id_ready_i  in  SW  first stage index whose output holds the result: 0 = ALU (EX), 1 = load (MEM); legal range 0..STAGES-2
- flush_i  in  1  squash the ID instruction this cycle
- stall_o  out  1  hold IF/ID and insert a bubble into EX (combinational)
- fwd_sel_o  out  NUM_RS*SW  registered select per port for the instruction now in EX: 0 = register file, k = pipeline register feeding stage k (1 = EX/MEM, 2 = MEM/WB, …)
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- Slot state: each of the STAGES slots holds {valid, rd[AW], ready[SW]}.
- Every clock edge the slots shift: slot k+1 ← slot k, and slot STAGES-1 retires.
- Slot 0 load rule: slot 0 ← {1, id_rd_i, id_ready_i} when `accept = id_valid_i & !stall_o & !flush_i & id_regwrite_i & (id_rd_i != 0)`. Otherwise slot 0 ← invalid (a bubble).
- Match for port p at slot j: slot j valid, rd == id_rs_i[p], id_rs_used_i[p] = 1, id_rs_i[p] != 0.
- Matching is checked over j = 0..STAGES-2 only. The register file is write-first, so a slot STAGES-1 producer needs no forwarding.
- Priority: the youngest match (lowest j) wins.
- Forwarding decision for port p with winning match j:
  - ready ≤ j: next-cycle select = j+1.
  - ready > j: hazard.
  - No match: select = 0.
- stall_o = id_valid_i & !flush_i & (any port has a hazard).
- fwd_sel_o register update each edge:
  - ID instruction valid, not stalled, not flushed: load the computed selects.
  - Otherwise: load 0 (the bubble uses no forwarding).
- stall_cnt_o increments on each edge where stall_o = 1 and holds at all-ones.
- Reset: all slots invalid, fwd_sel_o = 0, stall_cnt_o = 0. stall_o = 0 while rst_i is high.
- Illegal input id_ready_i > STAGES-2: behaviour undefined. The bench checks it with an assertion.

## Timing
- stall_o is valid in the same cycle as the ID inputs and has zero latency.
- fwd_sel_o is valid for one cycle, the cycle after the instruction leaves ID, when it occupies EX.
- Load-use with the default STAGES=3 and a load in EX: exactly 1 stall cycle, then select = 2 (MEM/WB).
- A stalled instruction is re-evaluated every cycle. The producer advances one slot per cycle, so the stall always clears within STAGES-1 cycles.
- flush_i has priority over stall in the same cycle: stall_o = 0 and a bubble is inserted.
- Asynchronous reset mid-stall: the in-flight state is dropped immediately, with no held stall after rst_i deasserts.
- Back-to-back producers to the same rd: the youngest wins. Test: ALU then ALU to x5, with the consumer reading x5 → select = 1.

## Test plan
- Reset then idle: assert rst_i mid-run → stall_o = 0, fwd_sel_o = 0, stall_cnt_o = 0 within the same cycle, and they stay so.
- ALU chain: addi x5 (ready 0), then the next ID reads rs1 = x5 → no stall; fwd_sel_o port 0 = 1 in the following cycle.
- Two-apart use: producer x6, unrelated instruction, consumer reads rs2 = x6 → port 1 select = 2; the other port = 0.
- Load-use: lw x7 (ready 1), next ID reads x7 on both ports → stall_o = 1 for 1 cycle; stall_cnt_o = 1; then both selects = 2.
- x0 and flush:
  - Producer to x0, consumer reads x0 → select = 0 and no stall.
  - flush_i during a load-use hazard → stall_o = 0; the next fwd_sel_o = 0.
- STAGES=5, NUM_RS=3 build: producer with ready 2, consumer directly behind → 2 stall cycles, then select = 3; stall_cnt_o saturates at 2^CNT_W-1 (CNT_W=4) under continuous forced stalls.
